// File: rtl/subpel_pkg.sv
// ----------------------------------------------------------------------------
// subpel_pkg: shared types and coefficient tables for the sub-pel interpolator
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package subpel_pkg;

  typedef logic signed [7:0] coef_t;
  typedef coef_t coefSet_t [8];

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  localparam int ROUND = 32;
  localparam int SHIFT = 6;

  // Index j multiplies p[n-3+j]; every set sums to 64.
  localparam coefSet_t c_EXACT_A  = '{-8'sd1, 8'sd4, -8'sd10, 8'sd58, 8'sd17, -8'sd5, 8'sd1, 8'sd0};
  localparam coefSet_t c_EXACT_B  = '{-8'sd1, 8'sd4, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd4, -8'sd1};
  localparam coefSet_t c_EXACT_C  = '{8'sd0, 8'sd1, -8'sd5, 8'sd17, 8'sd58, -8'sd10, 8'sd4, -8'sd1};

  localparam coefSet_t c_APPROX_A = '{8'sd0, 8'sd0, -8'sd8, 8'sd56, 8'sd16, 8'sd0, 8'sd0, 8'sd0};
  localparam coefSet_t c_APPROX_B = '{8'sd0, 8'sd0, -8'sd8, 8'sd40, 8'sd40, -8'sd8, 8'sd0, 8'sd0};
  localparam coefSet_t c_APPROX_C = '{8'sd0, 8'sd0, 8'sd0, 8'sd16, 8'sd56, -8'sd8, 8'sd0, 8'sd0};

endpackage

`default_nettype wire

// File: rtl/subpel_interp_stream_fir8.sv
// ----------------------------------------------------------------------------
// subpel_fir8: combinational 8-tap dot product with rounding and pixel clip
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module subpel_fir8
  import subpel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int ACC_W = PIX_W + 8
) (
  input  logic [PIX_W-1:0] window [8],
  input  coefSet_t         coef,
  output logic [PIX_W-1:0] result
);

  localparam logic signed [ACC_W-1:0] c_PIX_MAX = ACC_W'((1 << PIX_W) - 1);

  logic signed [ACC_W-1:0] w_prod [8];
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_scaled;

  // window[0] is the newest pixel, so tap j reads window[7-j].
  for (genvar j = 0; j < 8; j++) begin : g_tap
    assign w_prod[j] = $signed(ACC_W'($signed({1'b0, window[7-j]}))) *
                       $signed(ACC_W'(coef[j]));
  end

  always_comb begin
    w_sum = ACC_W'(ROUND);
    for (int j = 0; j < 8; j++) begin
      w_sum = w_sum + w_prod[j];
    end
  end

  assign w_scaled = w_sum >>> SHIFT;

  always_comb begin
    if (w_scaled[ACC_W-1]) begin
      result = '0;
    end else if (w_scaled > c_PIX_MAX) begin
      result = '1;
    end else begin
      result = w_scaled[PIX_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/subpel_interp_stream.sv
// ----------------------------------------------------------------------------
// subpel_interp_stream: streaming 1-D 8-tap quarter/half/three-quarter pel filter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module subpel_interp_stream
  import subpel_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int LINE_LEN = 16,
  parameter int ACC_W    = PIX_W + 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             approx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_a,
  output logic [PIX_W-1:0] out_b,
  output logic [PIX_W-1:0] out_c,
  output logic             out_last
);

  localparam int                 c_COL_W    = $clog2(LINE_LEN);
  localparam logic [c_COL_W-1:0] c_LAST_COL = c_COL_W'(LINE_LEN - 1);
  localparam logic [c_COL_W-1:0] c_FILL_END = c_COL_W'(3);

  state_t             r_state;
  logic [c_COL_W-1:0] r_col;
  logic [1:0]         r_flushCnt;
  logic               r_approxSel;
  logic               r_active;
  logic [PIX_W-1:0]   r_window [8];

  logic               w_adv;
  logic               w_accept;
  logic [PIX_W-1:0]   w_shiftIn;
  logic [PIX_W-1:0]   w_shifted [8];
  logic [PIX_W-1:0]   w_nextA;
  logic [PIX_W-1:0]   w_nextB;
  logic [PIX_W-1:0]   w_nextC;
  coefSet_t           w_coefA;
  coefSet_t           w_coefB;
  coefSet_t           w_coefC;

  assign w_adv     = !out_valid || out_ready;
  // r_active keeps in_ready low while reset is asserted and for the cycle after.
  assign in_ready  = r_active && w_adv && (r_state != FLUSH);
  assign w_accept  = in_valid && in_ready;
  assign w_shiftIn = (r_state == FLUSH) ? r_window[0] : in_pix;

  always_comb begin
    w_shifted[0] = w_shiftIn;
    for (int i = 1; i < 8; i++) begin
      w_shifted[i] = r_window[i-1];
    end
  end

  always_comb begin
    if (r_approxSel) begin
      w_coefA = c_APPROX_A;
      w_coefB = c_APPROX_B;
      w_coefC = c_APPROX_C;
    end else begin
      w_coefA = c_EXACT_A;
      w_coefB = c_EXACT_B;
      w_coefC = c_EXACT_C;
    end
  end

  subpel_fir8 #(.PIX_W(PIX_W), .ACC_W(ACC_W)) u_firA (
    .window (w_shifted),
    .coef   (w_coefA),
    .result (w_nextA)
  );

  subpel_fir8 #(.PIX_W(PIX_W), .ACC_W(ACC_W)) u_firB (
    .window (w_shifted),
    .coef   (w_coefB),
    .result (w_nextB)
  );

  subpel_fir8 #(.PIX_W(PIX_W), .ACC_W(ACC_W)) u_firC (
    .window (w_shifted),
    .coef   (w_coefC),
    .result (w_nextC)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= FILL;
      r_col       <= '0;
      r_flushCnt  <= '0;
      r_approxSel <= 1'b0;
      r_active    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_window[i] <= '0;
      end
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_a       <= '0;
      out_b       <= '0;
      out_c       <= '0;
    end else begin
      r_active <= 1'b1;
      if (w_adv) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      case (r_state)
        FILL: begin
          if (w_accept) begin
            // Pixel 0 preloads the whole window, giving left-edge replication.
            if (r_col == '0) begin
              for (int i = 0; i < 8; i++) begin
                r_window[i] <= in_pix;
              end
              r_approxSel <= approx;
            end else begin
              for (int i = 0; i < 8; i++) begin
                r_window[i] <= w_shifted[i];
              end
            end
            r_col <= r_col + c_COL_W'(1);
            if (r_col == c_FILL_END) begin
              r_state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (w_accept) begin
            for (int i = 0; i < 8; i++) begin
              r_window[i] <= w_shifted[i];
            end
            out_a     <= w_nextA;
            out_b     <= w_nextB;
            out_c     <= w_nextC;
            out_valid <= 1'b1;
            if (r_col == c_LAST_COL) begin
              r_col   <= '0;
              r_state <= FLUSH;
            end else begin
              r_col <= r_col + c_COL_W'(1);
            end
          end
        end
        FLUSH: begin
          if (w_adv) begin
            for (int i = 0; i < 8; i++) begin
              r_window[i] <= w_shifted[i];
            end
            out_a      <= w_nextA;
            out_b      <= w_nextB;
            out_c      <= w_nextC;
            out_valid  <= 1'b1;
            r_flushCnt <= r_flushCnt + 2'd1;
            if (r_flushCnt == 2'd3) begin
              out_last <= 1'b1;
              r_state  <= FILL;
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/subpel_interp_stream.md
Name: subpel_interp_stream

Overview:
- Streaming 1-D 8-tap sub-pixel interpolator with valid/ready handshakes.
- Accepts one line of LINE_LEN integer pixels and emits LINE_LEN output beats. Each beat carries quarter (a), half (b) and three-quarter (c) samples at offsets +1/4, +1/2, +3/4 after integer pixel n.
- Replicates edge pixels internally, rounds, and clips to pixel range.
- Selectable exact or approximate coefficient sets, for use in both the horizontal and the vertical (transposed-feed) interpolation passes.

Parameters:
- PIX_W, 8, pixel width in bits (unsigned).
- LINE_LEN, 16, pixels per line; must be at least 5.
- ACC_W, PIX_W+8, signed accumulator width (derived; do not override).

Ports:
- clock, input, 1, single clock.
- reset_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, in_pix is valid.
- in_ready, output, 1, block accepts in_pix this cycle.
- in_pix, input, PIX_W, integer pixel, raster order within the line.
- approx, input, 1, 0 selects exact coefficients, 1 selects approximate; sampled with pixel 0 of each line.
- out_valid, output, 1, output beat valid.
- out_ready, input, 1, downstream accepts the beat.
- out_a, output, PIX_W, quarter-pel sample.
- out_b, output, PIX_W, half-pel sample.
- out_c, output, PIX_W, three-quarter-pel sample.
- out_last, output, 1, marks beat LINE_LEN-1 of the line.

Behaviour:
- Reset (asynchronous, reset_n=0): state=FILL, col=0, flush_cnt=0, window cleared. Outputs out_valid=0, out_a/b/c=0, out_last=0, in_ready=0. A reset mid-line discards the partial line and all pending output.
- Window: 8 x PIX_W shift register w[0..7], w[0] newest. Output n uses p[n-3..n+4]. Tap j (j=0..7) multiplies p[n-3+j].
- Exact coefficients:
  - a: -1, 4, -10, 58, 17, -5, 1, 0
  - b: -1, 4, -11, 40, 40, -11, 4, -1
  - c: 0, 1, -5, 17, 58, -10, 4, -1
- Approximate coefficients (shift/add only):
  - a: 0, 0, -8, 56, 16, 0, 0, 0
  - b: 0, 0, -8, 40, 40, -8, 0, 0
  - c: 0, 0, 0, 16, 56, -8, 0, 0
- Arithmetic: each coefficient set sums to 64. sample = clip((sum + 32) >>> 6, 0, 2^PIX_W - 1), where >>> is an arithmetic shift and the sum is signed ACC_W.
- Edge handling: p[k<0] = p[0] and p[k>LINE_LEN-1] = p[LINE_LEN-1].
- Advance condition: adv = !out_valid || out_ready.
- in_ready = adv && state != FLUSH.
- State FILL (col 0..3):
  - Pixel accept at col 0 loads all 8 window entries with the pixel and latches approx.
  - Accepts at cols 1..3 shift the window in. No output.
  - Transition to STREAM after the col=3 accept.
- State STREAM (col 4..LINE_LEN-1):
  - An accept of pixel k shifts it in and registers output k-4. out_valid is asserted the following cycle; latency is 1 cycle from accept to beat.
  - After the accept at col=LINE_LEN-1, go to FLUSH.
- State FLUSH:
  - 4 beats; each advance shifts in a replica of p[LINE_LEN-1] and registers outputs LINE_LEN-4..LINE_LEN-1.
  - out_last=1 with the final beat.
  - Then return to FILL with col=0. The next line's pixel 0 may be accepted in the cycle after the last FLUSH advance.
- Backpressure: when out_valid=1 and out_ready=0, all outputs hold stable and the window does not move. No beat is dropped or duplicated.
- in_valid=0 in FILL/STREAM: no state change; out_valid drops once the pending beat is taken.
- approx toggling mid-line has no effect until the next pixel 0.
- Per line: exactly LINE_LEN accepts and LINE_LEN beats.

Decomposition:
- Package subpel_pkg holds:
  - the three exact and three approximate coefficient arrays, as signed 8-bit localparams;
  - the state enum {FILL, STREAM, FLUSH};
  - ROUND=32 and SHIFT=6.
- Sub-module subpel_fir8: combinational 8-tap dot product plus round and clip. Ports: window, coefficient set, PIX_W result.
- Instantiate subpel_fir8 three times (a, b, c). The top holds the window, counters, FSM and output register.

Test Plan:
- Flat line, all pixels 100, exact and approx modes, out_ready=1 → 16 beats, every a/b/c = 100, out_last only on beat 15, in_ready low for 4 FLUSH cycles.
- Step line p0..p3=0, p4..p15=255, exact mode → beat 3: a=52, b=128; beat 4: a=255 (raw 283 clipped); beat 0: a=b=c=0.
- Same step line, approx=1 → beat 3: a=64; beat 4: a=255.
- Impulse: all 0 except p8=255, exact mode → beat 4: b=0 (raw -4 clipped), no underflow wrap.
- Random out_ready (about 50% duty) over 3 back-to-back random lines → beat stream identical to the out_ready=1 golden model; outputs stable while stalled; 48 beats total.
- Assert reset_n=0 asynchronously at mid-line col=9 → out_valid and in_ready drop immediately. After release, a fresh line produces correct 16 beats with no residue from the old line.
